blinky_multi: RTL and testbench

- Parametrised successor to the two-LED blinker: N independent LED channels.
- Each channel has a runtime-configurable mode (off / solid / blink / one-shot) and a period counted in prescaled ticks.
- Configuration arrives over a single valid/ready write port; one shared prescaler derives the tick from the board clock.
- Sits between top-level control logic and LED pins.

---
 rtl/blinky_multi.sv | 243 ++++++++++++++++++++++++
 tb/tb_blinky_multi.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blinky_multi.sv
// -----------------------------------------------------------------------------
// blinky_multi
//
// N independent LED channels. Each channel runs in one of four modes:
// OFF, SOLID, BLINK or ONESHOT. Its period is counted in ticks from a single
// shared prescaler. Channel configuration is written through one valid/ready
// port.
//
// Optional build feature:
//   BLINKY_MULTI_PWM_EN - when defined, each channel stores a duty value. A
//   free-running PWM counter then gates the LED drive. When undefined, cfg_duty
//   is ignored and the LED shows the unmodulated channel state. The port list
//   is the same in both builds.
//
// Ports:
//   clk         in   clock; all logic on the rising edge
//   reset       in   asynchronous, active-low reset (0 = in reset)
//   en          in   per-channel enable; 0 darkens and freezes the channel
//   cfg_valid   in   configuration write request
//   cfg_ready   out  configuration port can accept (1 from first edge after reset)
//   cfg_chan    in   target channel index
//   cfg_mode    in   0=OFF 1=SOLID 2=BLINK 3=ONESHOT
//   cfg_period  in   half-period (BLINK) or pulse length (ONESHOT) in ticks
//   cfg_duty    in   brightness (PWM build only)
//   cfg_err     out  one-cycle pulse after a write to a nonexistent channel
//   tick        out  one-cycle prescaler pulse
//   busy        out  registered: channel is in ONESHOT and still high
//   led         out  registered LED drive
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module blinky_multi #(
    parameter int CHANNELS       = 2,
    parameter int CLK_HZ         = 24_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int CNT_W          = 16,
    parameter int PERIOD_DEFAULT = 500,
    parameter int PWM_BITS       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                cfg_err,
    output logic                tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] led
);

    localparam int                  DIV        = CLK_HZ / TICK_HZ;
    localparam int                  PRESC_W    = $clog2(DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    PERIOD_RST = CNT_W'(PERIOD_DEFAULT);
    localparam logic [4:0]          CHAN_LIMIT = 5'(CHANNELS);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Shared prescaler. It runs freely and configuration writes never touch it.
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;

    // NOTE: sequential state is written with non-blocking assignments, so every
    // flop samples the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_ONE;
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    // ------------------------------------------------------------------
    // Configuration port
    // ------------------------------------------------------------------
    logic wr_fire;
    logic chan_ok;

    assign wr_fire = cfg_valid & cfg_ready;
    assign chan_ok = ({1'b0, cfg_chan} < CHAN_LIMIT);

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    mode_t               mode_q   [CHANNELS];
    mode_t               mode_d   [CHANNELS];
    logic [CNT_W-1:0]    period_q [CHANNELS];
    logic [CNT_W-1:0]    period_d [CHANNELS];
    logic [CNT_W-1:0]    count_q  [CHANNELS];
    logic [CNT_W-1:0]    count_d  [CHANNELS];
    logic [CHANNELS-1:0] phase_q;
    logic [CHANNELS-1:0] phase_d;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] on_state;
    logic [CHANNELS-1:0] gate;

    // Next-state logic. A write to a channel takes priority, so a tick that
    // arrives in the same cycle is dropped for that channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every next-state value is defaulted before any branch, so no
            // path leaves it unassigned and no latch is inferred.
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
            phase_d[i]  = phase_q[i];
            wr_sel[i]   = wr_fire && chan_ok && (cfg_chan == 4'(i));

            if (wr_sel[i]) begin
                mode_d[i]   = mode_t'(cfg_mode);
                period_d[i] = (cfg_period == '0) ? CNT_ONE : cfg_period;
                count_d[i]  = '0;
                phase_d[i]  = 1'b1;
            end else if (tick && en[i]) begin
                unique case (mode_q[i])
                    MODE_BLINK: begin
                        if (count_q[i] == period_q[i] - CNT_ONE) begin
                            count_d[i] = '0;
                            phase_d[i] = ~phase_q[i];
                        end else begin
                            count_d[i] = count_q[i] + CNT_ONE;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (count_q[i] == period_q[i] - CNT_ONE) begin
                            count_d[i] = '0;
                            phase_d[i] = 1'b0;
                            mode_d[i]  = MODE_OFF;
                        end else begin
                            count_d[i] = count_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        // OFF and SOLID hold their count.
                    end
                endcase
            end
        end
    end

    // NOTE: the channel arrays are ordinary flop arrays rather than a RAM, so
    // they are reset explicitly like every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= PERIOD_RST;
                count_q[i]  <= '0;
            end
            phase_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
            phase_q <= phase_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            unique case (mode_q[i])
                MODE_OFF:   on_state[i] = 1'b0;
                MODE_SOLID: on_state[i] = 1'b1;
                default:    on_state[i] = phase_q[i];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Brightness gate
    // ------------------------------------------------------------------
`ifdef BLINKY_MULTI_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q [CHANNELS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= '1;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    duty_q[i] <= cfg_duty;
                end
            end
        end
    end

    // Full-scale duty means always on. Without that special case the
    // strict compare would leave one dark cycle per PWM frame.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            gate[i] = (duty_q[i] == '1) || (pwm_cnt < duty_q[i]);
        end
    end
`else
    logic cfg_duty_unused;

    assign gate            = '1;
    assign cfg_duty_unused = ^cfg_duty;
`endif

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led       <= '0;
            busy      <= '0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            led       <= en & on_state & gate;
            cfg_err   <= wr_fire & ~chan_ok;
            cfg_ready <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                busy[i] <= (mode_q[i] == MODE_ONESHOT) & phase_q[i];
            end
        end
    end

endmodule

// File: tb/tb_blinky_multi.sv
`timescale 1ns/1ps

module tb_blinky_multi;

    localparam int CH  = 2;
    localparam int DIV = 10;
`ifdef BLINKY_MULTI_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_chan;
    logic [1:0]    cfg_mode;
    logic [15:0]   cfg_period;
    logic [7:0]    cfg_duty;
    logic          cfg_err;
    logic          tick;
    logic [CH-1:0] busy;
    logic [CH-1:0] led;

    int total = 0;
    int bad   = 0;

    blinky_multi #(
        .CHANNELS(CH), .CLK_HZ(1000), .TICK_HZ(100),
        .CNT_W(16), .PERIOD_DEFAULT(500), .PWM_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_err(cfg_err), .tick(tick), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. A channel is described by how many enabled ticks
    // have passed since its last write (its age). A BLINK channel is lit
    // during even multiples of its period. A ONESHOT channel is lit until
    // its age reaches the period, and then it becomes OFF.
    // ------------------------------------------------------------------
    int            m_mode   [CH];
    int            m_period [CH];
    int            m_age    [CH];
    int            m_duty   [CH];
    int            m_cyc;
    bit            m_ready;
    logic [CH-1:0] e_led, e_busy;
    logic          e_err, e_tick;

    assign e_tick = ((m_cyc % DIV) == DIV - 1);

    function automatic bit m_lit(input int mode, input int age, input int period);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((age / period) % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_gate(input int duty, input int cyc);
        return !PWM_ON || duty == 255 || (cyc % 256) < duty;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < CH; ch++) begin
                m_mode[ch]   <= 0;
                m_period[ch] <= 500;
                m_age[ch]    <= 0;
                m_duty[ch]   <= 255;
            end
            m_cyc   <= 0;
            m_ready <= 1'b0;
            e_led   <= '0;
            e_busy  <= '0;
            e_err   <= 1'b0;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                e_led[ch]  <= en[ch] && m_lit(m_mode[ch], m_age[ch], m_period[ch])
                              && m_gate(m_duty[ch], m_cyc);
                e_busy[ch] <= (m_mode[ch] == 3);
                if (cfg_valid && m_ready && int'(cfg_chan) == ch) begin
                    m_mode[ch]   <= int'(cfg_mode);
                    m_period[ch] <= (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_age[ch]    <= 0;
                    m_duty[ch]   <= int'(cfg_duty);
                end else if (e_tick && en[ch] && m_mode[ch] >= 2) begin
                    m_age[ch] <= m_age[ch] + 1;
                    if (m_mode[ch] == 3 && m_age[ch] + 1 >= m_period[ch]) m_mode[ch] <= 0;
                end
            end
            e_err   <= cfg_valid && m_ready && (int'(cfg_chan) >= CH);
            m_ready <= 1'b1;
            m_cyc   <= m_cyc + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helper: a write is presented at a falling edge and is
    // accepted on the next rising edge. The task returns at the falling
    // edge that follows acceptance.
    // ------------------------------------------------------------------
    task automatic cfg_write(input logic [3:0] c, input logic [1:0] m,
                             input logic [15:0] p, input logic [7:0] d);
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_chan   = c;
        cfg_mode   = m;
        cfg_period = p;
        cfg_duty   = d;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 2'b11; cfg_valid = 1'b0;
        cfg_chan = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
        #23;
        total++;
        if ({led, busy, tick, cfg_err, cfg_ready} !== 7'b0) begin
            bad++; $display("FAIL reset_hold got=%b want=0", {led, busy, tick, cfg_err, cfg_ready});
        end
        #9 reset = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", cfg_ready); end
        @(posedge clk); #1;
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b want=1", cfg_ready); end

        cfg_write(4'd0, 2'd2, 16'd3, 8'hff);
        repeat (15) @(negedge clk);
        total++;
        if (led[0] !== 1'b1) begin bad++; $display("FAIL reset_blink_running got=%b want=1", led[0]); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({led, busy, tick, cfg_err, cfg_ready} !== 7'b0) begin
            bad++; $display("FAIL async_clear got=%b want=0", {led, busy, tick, cfg_err, cfg_ready});
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ready_rerelease got=%b want=0", cfg_ready); end
        @(posedge clk); #1;
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_rerelease_edge got=%b want=1", cfg_ready); end
    endtask

    task automatic test_blink;
        int tr[$];
        logic last;
        bit   led1_seen;
        en = 2'b11;
        cfg_write(4'd0, 2'd2, 16'd3, 8'hff);
        total++;
        if (led[0] !== 1'b0) begin bad++; $display("FAIL blink_pre_rise got=%b want=0", led[0]); end
        last = 1'b0;
        led1_seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL blink_model k=%0d got=%b want=%b", k,
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
            if (led[1] !== 1'b0) led1_seen = 1'b1;
            if (led[0] !== last) begin tr.push_back(k); last = led[0]; end
        end
        total++;
        if (led1_seen) begin bad++; $display("FAIL blink_led1_dark got=1 want=0"); end
        total++;
        if (tr.size() < 4) begin
            bad++; $display("FAIL blink_transitions got=%0d want>=4", tr.size());
        end else begin
            total++;
            if (tr[0] != 1) begin bad++; $display("FAIL blink_first_rise got=%0d want=1", tr[0]); end
            total++;
            if (tr[1] - tr[0] < 21 || tr[1] - tr[0] > 30) begin
                bad++; $display("FAIL blink_first_high got=%0d want=21..30", tr[1] - tr[0]);
            end
            for (int i = 2; i < tr.size(); i++) begin
                total++;
                if (tr[i] - tr[i-1] != 30) begin
                    bad++; $display("FAIL blink_interval i=%0d got=%0d want=30", i, tr[i] - tr[i-1]);
                end
            end
        end
    endtask

    task automatic test_oneshot;
        int hi;
        bit split;
        en = 2'b11;
        cfg_write(4'd0, 2'd0, 16'd1, 8'hff);
        cfg_write(4'd1, 2'd3, 16'd5, 8'hff);
        hi = 0; split = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (led[1] !== busy[1]) split = 1'b1;
            if (led[1] === 1'b1) hi++;
        end
        total++;
        if (split) begin bad++; $display("FAIL oneshot_busy_tracks_led got=differ want=equal"); end
        total++;
        if (hi < 41 || hi > 50) begin bad++; $display("FAIL oneshot_len got=%0d want=41..50", hi); end
        total++;
        if ({led[1], busy[1]} !== 2'b00) begin bad++; $display("FAIL oneshot_end got=%b want=00", {led[1], busy[1]}); end

        cfg_write(4'd1, 2'd3, 16'd0, 8'hff);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (led[1] === 1'b1) hi++;
        end
        total++;
        if (hi < 1 || hi > 10) begin bad++; $display("FAIL oneshot_period0_len got=%0d want=1..10", hi); end
    endtask

    task automatic test_freeze;
        int   rises, h1, h2;
        logic prev;
        bit   lit;
        en = 2'b11;
        cfg_write(4'd1, 2'd0, 16'd1, 8'hff);
        cfg_write(4'd0, 2'd2, 16'd2, 8'hff);
        rises = 0; prev = led[0];
        for (int g = 0; g < 200 && rises < 2; g++) begin
            @(negedge clk);
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL freeze_model_a got=%b want=%b",
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
            if (led[0] === 1'b1 && prev === 1'b0) rises++;
            prev = led[0];
        end
        total++;
        if (rises != 2) begin bad++; $display("FAIL freeze_sync got=%0d want=2", rises); end
        h1 = 1;
        repeat (5) begin
            @(negedge clk);
            if (led[0] === 1'b1) h1++;
        end
        en[0] = 1'b0;
        lit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (led[0] !== 1'b0) lit = 1'b1;
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL freeze_model_b got=%b want=%b",
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
        end
        total++;
        if (lit) begin bad++; $display("FAIL freeze_dark got=1 want=0"); end
        en[0] = 1'b1;
        h2 = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL freeze_model_c got=%b want=%b",
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
            if (led[0] === 1'b1) h2++;
            else break;
        end
        total++;
        if (h1 + h2 < 20 - DIV || h1 + h2 > 20 + DIV) begin
            bad++; $display("FAIL freeze_resume got=%0d want=10..30", h1 + h2);
        end
    endtask

    task automatic test_bad_chan;
        int  hi;
        bit  found;
        en = 2'b11;
        cfg_write(4'd0, 2'd1, 16'd1, 8'hff);
        cfg_write(4'd1, 2'd3, 16'd100, 8'hff);
        @(negedge clk);
        total++;
        if ({led, busy} !== 4'b1110) begin bad++; $display("FAIL bad_setup got=%b want=1110", {led, busy}); end
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL bad_err_idle got=%b want=0", cfg_err); end
        cfg_write(4'd5, 2'd2, 16'd7, 8'h00);
        total++;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad_err_pulse got=%b want=1", cfg_err); end
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL bad_err_single got=%b want=0", cfg_err); end
        repeat (3) @(negedge clk);
        total++;
        if ({led, busy} !== 4'b1110) begin bad++; $display("FAIL bad_no_change got=%b want=1110", {led, busy}); end

        // A write that lands on a tick cycle must restart the count at zero.
        cfg_write(4'd0, 2'd0, 16'd1, 8'hff);
        found = 1'b0;
        for (int g = 0; g < 2 * DIV; g++) begin
            @(negedge clk);
            if (tick === 1'b1) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL coinc_tick_found got=0 want=1"); end
        cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_mode = 2'd2; cfg_period = 16'd1; cfg_duty = 8'hff;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++;
        if (led[0] !== 1'b0) begin bad++; $display("FAIL coinc_pre got=%b want=0", led[0]); end
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (led[0] === 1'b1) hi++;
            else break;
        end
        total++;
        if (hi != DIV) begin bad++; $display("FAIL coinc_high got=%0d want=%0d", hi, DIV); end
    endtask

    task automatic test_pwm;
        int hi;
        int duties[3];
        duties = '{64, 255, 0};
        en = 2'b11;
        cfg_write(4'd1, 2'd0, 16'd1, 8'hff);
        for (int t = 0; t < 3; t++) begin
            cfg_write(4'd0, 2'd1, 16'd1, 8'(duties[t]));
            repeat (2) @(negedge clk);
            hi = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                if (led[0] === 1'b1) hi++;
            end
            total++;
            if (hi != (PWM_ON ? ((duties[t] == 255) ? 256 : duties[t]) : 256)) begin
                bad++; $display("FAIL pwm_duty_%0d got=%0d want=%0d", duties[t], hi,
                                PWM_ON ? ((duties[t] == 255) ? 256 : duties[t]) : 256);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL random k=%0d got=%b want=%b", k,
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_chan   = 4'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = 16'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0:       cfg_duty = 8'd0;
                1:       cfg_duty = 8'hff;
                default: cfg_duty = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 15) == 0) en = 2'($urandom_range(0, 3));
        end
        cfg_valid = 1'b0;
        en = 2'b11;
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({led, busy, tick, cfg_err, cfg_ready} !== {e_led, e_busy, e_tick, e_err, m_ready}) begin
                bad++; $display("FAIL random_tail got=%b want=%b",
                                {led, busy, tick, cfg_err, cfg_ready}, {e_led, e_busy, e_tick, e_err, m_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_freeze();
        test_bad_chan();
        test_pwm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
